// File: rtl/bus_fifo_slave.sv
// bus_fifo_slave: 32-bit circular-buffer FIFO for a simple bus slave.
// This is a show-ahead FIFO: the head entry is always visible on read_data.
// The overflow and underflow flags are sticky.
//
// Ports:
//   clk        - sole clock; all state changes on its rising edge
//   rst        - asynchronous active-high reset
//   write      - push request; write_data is sampled when write=1
//   write_data - push payload
//   read       - pop request; the popped word is on read_data in the same cycle
//   read_data  - head-of-queue data (combinational), 0 when empty
//   clear      - synchronous flush; overrides a same-cycle write or read
//   count      - occupancy, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
//   overflow   - sticky: a write was attempted while full with no read
//   underflow  - sticky: a read was attempted while empty
module bus_fifo_slave #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          write,
  input  logic [31:0]   write_data,
  input  logic          read,
  output logic [31:0]   read_data,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = 32;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;
  logic          wr_acc;
  logic          rd_acc;

  // Status flags are derived from the occupancy counter only.
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // A same-cycle read frees the slot, so a write into a full FIFO is still accepted.
  assign wr_acc = write && (!full || read);
  assign rd_acc = read && !empty;

  // Show-ahead head. It is masked to zero when empty, so stale or unwritten entries never leak out.
  assign read_data = empty ? '0 : mem[rd_ptr];

  // Storage is left unreset. Pointer and count state alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_acc) begin
      mem[wr_ptr] <= write_data;
    end
  end

  // Pointers, occupancy and sticky flags.
  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_acc && !rd_acc) begin
        count_q <= count_q + CW'(1);
      end else if (!wr_acc && rd_acc) begin
        count_q <= count_q - CW'(1);
      end
      if (write && full && !read) begin
        overflow_q <= 1'b1;
      end
      if (read && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fifo_slave.sv
// tb_bus_fifo_slave: directed and randomized checks of bus_fifo_slave.
// The reference is a queue-based FIFO model with sticky error flags.
module tb_bus_fifo_slave;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          write;
  logic [31:0]   write_data;
  logic          read;
  logic [31:0]   read_data;
  logic          clear;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] q[$];
  bit          m_ov;
  bit          m_un;

  bus_fifo_slave #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .write_data (write_data),
    .read       (read),
    .read_data  (read_data),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_head;
    exp_head = (q.size() > 0) ? q[0] : 32'h0;
    check({tag, "/count"},     32'(count),     32'(q.size()));
    check({tag, "/full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, "/empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, "/read_data"}, read_data,      exp_head);
    check({tag, "/overflow"},  32'(overflow),  32'(m_ov));
    check({tag, "/underflow"}, 32'(underflow), 32'(m_un));
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  // Behavioural effect of one clock edge on the model.
  task automatic model_step(input bit w, input logic [31:0] wd, input bit r, input bit c);
    int  sz;
    bit  pop;
    bit  push;
    sz = q.size();
    if (c) begin
      model_reset();
    end else begin
      pop  = r && (sz > 0);
      push = w && ((sz < DEPTH) || r);
      if (r && sz == 0) m_un = 1'b1;
      if (w && sz == DEPTH && !r) m_ov = 1'b1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(wd);
    end
  endtask

  // One bus cycle: drive the inputs, check the pre-edge outputs at negedge,
  // then clock the edge and advance the model.
  task automatic cyc(input string tag, input bit w, input logic [31:0] wd, input bit r, input bit c);
    write      = w;
    write_data = wd;
    read       = r;
    clear      = c;
    @(negedge clk);
    check_state(tag);
    @(posedge clk);
    model_step(w, wd, r, c);
    #1;
    write = 1'b0;
    read  = 1'b0;
    clear = 1'b0;
  endtask

  // Build the state count=5 with overflow=1: fill, overrun once, then pop three.
  task automatic build_five_ov();
    for (int i = 0; i < DEPTH; i++) cyc("fill5", 1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0);
    cyc("ovr5", 1'b1, 32'hBAD0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("pop5", 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    write      = 1'b0;
    write_data = 32'h0;
    read       = 1'b0;
    clear      = 1'b0;
    model_reset();

    // Reset state; stimulus applied under reset is ignored.
    #1;
    check_state("reset");
    write = 1'b1; write_data = 32'hFFFF_0001; read = 1'b1;
    @(posedge clk); #1;
    check_state("reset_ignore");
    write = 1'b0; read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic ordering A0..A2.
    for (int i = 0; i < 3; i++) cyc("push_a", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("pop_a", 1'b0, 32'h0, 1'b1, 1'b0);
    cyc("after_a", 1'b0, 32'h0, 1'b0, 1'b0);

    // Fill, then overrun with DEAD.
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    cyc("dead", 1'b1, 32'hDEAD, 1'b0, 1'b0);
    cyc("after_dead", 1'b0, 32'h0, 1'b0, 1'b0);

    // Clear, refill, then push BEEF with a simultaneous read while full.
    cyc("clr1", 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    cyc("beef", 1'b1, 32'hBEEF, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 1'b0, 32'h0, 1'b1, 1'b0);

    // Empty FIFO with write+read: the write lands and the read underflows.
    cyc("clr2", 1'b0, 32'h0, 1'b0, 1'b1);
    cyc("wr_rd_empty", 1'b1, 32'h1234, 1'b1, 1'b0);
    cyc("after_1234", 1'b0, 32'h0, 1'b0, 1'b0);
    cyc("pop_1234", 1'b0, 32'h0, 1'b1, 1'b0);

    // Interleaved push/pop across pointer wrap, starting with clean flags.
    cyc("clr3", 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc("wrap_push", 1'b1, 32'hC00 + 32'(i), 1'b0, 1'b0);
      cyc("wrap_pop",  1'b0, 32'h0, 1'b1, 1'b0);
    end
    cyc("wrap_end", 1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset between edges, held across one edge with write pending.
    build_five_ov();
    cyc("five_ov", 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    write = 1'b1; write_data = 32'h7777;
    #1;
    model_reset();
    check_state("async_rst");
    @(posedge clk); #1;
    check_state("rst_hold");
    write = 1'b0;
    rst = 1'b0;
    cyc("post_rst_push", 1'b1, 32'h4242, 1'b0, 1'b0);
    cyc("post_rst_head", 1'b0, 32'h0, 1'b1, 1'b0);

    // Same state, flushed with clear while write and read are also requested.
    build_five_ov();
    cyc("clr_prio", 1'b1, 32'h9999, 1'b1, 1'b1);
    cyc("after_clr", 1'b0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      bit w;
      bit r;
      bit c;
      w = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      c = ($urandom_range(0, 99) < 2);
      cyc("rand", w, $urandom, r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_fifo_slave.md
BUS_FIFO_SLAVE -- requirements
Module: bus_fifo_slave

Interface
REQ-001 Parameter: DEPTH, default 8, number of 32-bit entries; SHALL be a power of two, >= 2.
REQ-002 Parameter: CW, default $clog2(DEPTH)+1, width of the count output.
REQ-003 Port: clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: write  input  1  push request from bus master.
REQ-006 Port: write_data  input  32  push payload, sampled when write=1.
REQ-007 Port: read  input  1  pop request from bus master.
REQ-008 Port: read_data  output  32  head-of-queue data.
REQ-009 Port: clear  input  1  synchronous flush.
REQ-010 Port: count  output  CW  current occupancy, 0..DEPTH.
REQ-011 Port: full  output  1  count==DEPTH.
REQ-012 Port: empty  output  1  count==0.
REQ-013 Port: overflow  output  1  sticky, write attempted while full with no read.
REQ-014 Port: underflow  output  1  sticky, read attempted while empty.

Function
REQ-015 Storage SHALL be a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 with no special case.
REQ-016 read_data SHALL be combinational: mem[rd_ptr] when empty=0, 32'h0 when empty=1; pop data SHALL be valid in the same cycle read=1.
REQ-017 Write accepted iff write=1 and (full=0 or read=1); accepted write SHALL store write_data at wr_ptr and increment wr_ptr on the same edge.
REQ-018 Read accepted iff read=1 and empty=0; accepted read SHALL increment rd_ptr.
REQ-019 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
REQ-020 Full with write=1, read=1: both accepted, count stays DEPTH, overflow not set.
REQ-021 Empty with write=1, read=1: write accepted, read rejected, count becomes 1, underflow set, read_data stays 32'h0 that cycle.
REQ-022 Write with full=1 and read=0: data dropped, pointers/count unchanged, overflow set next edge.
REQ-023 Read with empty=1: pointers unchanged, underflow set next edge.
REQ-024 overflow/underflow SHALL remain 1 until rst or clear.
REQ-025 clear=1 SHALL, on the next edge, zero pointers, count, overflow, underflow, and SHALL take priority over same-cycle write/read (both ignored).
REQ-026 full, empty SHALL derive from count only; no independent state.
REQ-027 Storage array contents need not be reset; no output SHALL expose unwritten entries.

Reset
REQ-028 rst=1 SHALL immediately, without clk, force wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0; hence empty=1, full=0, read_data=32'h0.
REQ-029 While rst=1 all write/read/clear inputs SHALL be ignored.
REQ-030 Reset asserted mid-operation SHALL discard all queued data; first accepted write after deassertion SHALL appear at read_data the next cycle.
REQ-031 rst deassertion SHALL be synchronised to clk by the integrator; block holds no reset synchroniser.

Verification
REQ-032 Push 32'hA0..32'hA2 over 3 cycles, then pop 3 -> read_data A0, A1, A2 in order; count 3 -> 0; empty=1 after.
REQ-033 Fill DEPTH=8 entries, push 32'hDEAD with read=0 -> full=1, count=8, overflow=1, DEAD never read back.
REQ-034 Full FIFO, write=1 read=1 with 32'hBEEF -> head popped, count stays 8, overflow=0, BEEF read out eighth.
REQ-035 Empty FIFO, write=1 read=1 with 32'h1234 -> underflow=1, count=1, next cycle read_data=32'h1234.
REQ-036 Push 12 / pop 12 interleaved to force pointer wrap -> data order preserved, no flag set.
REQ-037 With count=5 and overflow=1, assert rst between edges -> count=0, empty=1, overflow=0, read_data=32'h0 before next edge; repeat with clear -> same at next edge.
